// File: rtl/cdc_pkg.sv
// Shared clock-domain-crossing types and defaults for the handshake tx/rx pair.
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } hs_tx_state_t;

  localparam int DEFAULT_SYNC_STAGES = 2;

  // A disabled timeout (0) still needs a one-bit counter to elaborate cleanly.
  function automatic int timeout_cnt_w(input int timeout_cyc);
    return (timeout_cyc < 1) ? 1 : $clog2(timeout_cyc + 1);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Generic N-flop level synchronizer with asynchronous active-low clear.
module sync_ff
  import cdc_pkg::*;
#(
  parameter int STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source end of a 4-phase req/ack crossing: holds a captured word on tx_data,
// raises tx_req and completes return-to-zero against a synchronized tx_ack.
module cdc_handshake_tx
  import cdc_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              tx_req,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_ack,
  output logic              done,
  output logic              err_timeout
);

  // state   | meaning
  // IDLE    | no transfer; accepts a word when in_valid
  // REQ     | tx_req high, word frozen; waiting for ack_s rise or timeout
  // RELEASE | tx_req low, word still held; waiting for ack_s to fall

  localparam int CNT_W = timeout_cnt_w(TIMEOUT_CYC);
  localparam bit TO_EN = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  hs_tx_state_t     state;
  logic [CNT_W-1:0] cnt;
  logic             via_ack;
  logic             ack_s;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (tx_ack),
    .q      (ack_s)
  );

  assign in_ready = (state == IDLE);

  // Timeout is a down-counter loaded on accept; terminal count 0 marks the
  // TIMEOUT_CYC-th cycle spent in REQ.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      tx_req      <= 1'b0;
      tx_data     <= '0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      cnt         <= '0;
      via_ack     <= 1'b0;
    end else begin
      done        <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            tx_data <= in_data;
            tx_req  <= 1'b1;
            cnt     <= CNT_LOAD;
            state   <= REQ;
          end
        end
        REQ: begin
          if (ack_s) begin
            tx_req  <= 1'b0;
            via_ack <= 1'b1;
            state   <= RELEASE;
          end else if (TO_EN && (cnt == '0)) begin
            tx_req      <= 1'b0;
            via_ack     <= 1'b0;
            err_timeout <= 1'b1;
            state       <= RELEASE;
          end else if (TO_EN) begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RELEASE: begin
          if (!ack_s) begin
            done  <= via_ack;
            state <= IDLE;
          end
        end
        default: begin
          tx_req <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx with a small receive-side ack model.
module tb_cdc_handshake_tx;

  logic       clk;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       tx_ack;
  logic       done;
  logic       err_timeout;

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;
  int n_err    = 0;
  int n_both   = 0;

  cdc_handshake_tx #(
    .DATA_W     (8),
    .SYNC_STAGES(2),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .tx_req     (tx_req),
    .tx_data    (tx_data),
    .tx_ack     (tx_ack),
    .done       (done),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset_n) begin
      if (done) n_done++;
      if (err_timeout) n_err++;
      if (done && err_timeout) n_both++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic pick(input int which);
    case (which)
      0:       return tx_req;
      1:       return done;
      default: return in_ready;
    endcase
  endfunction

  // Bounded poll at negedges; an expired budget shows up as a failed check.
  task automatic wait_for(input string tag, input int which, input logic lvl, input int max);
    int n = 0;
    while (pick(which) !== lvl && n < max) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, pick(which)}, {31'd0, lvl});
  endtask

  // Receive-side model: called just after tx_req rises.
  task automatic handshake(input logic [7:0] word, input int ack_dly, input int drop_dly,
                           input int phase);
    tick(ack_dly);
    #(phase);
    check("rx_data_at_ack", {24'd0, tx_data}, {24'd0, word});
    tx_ack = 1'b1;
    wait_for("req_fall", 0, 1'b0, 8);
    check("data_held_release", {24'd0, tx_data}, {24'd0, word});
    tick(drop_dly);
    #(phase);
    tx_ack = 1'b0;
    wait_for("done_pulse", 1, 1'b1, 8);
  endtask

  initial begin
    int d0;
    int e0;
    logic [7:0] w;

    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    tx_ack   = 1'b0;

    // 1. reset
    tick(3);
    check("rst_req",   {31'd0, tx_req},      32'd0);
    check("rst_data",  {24'd0, tx_data},     32'd0);
    check("rst_ready", {31'd0, in_ready},    32'd1);
    check("rst_done",  {31'd0, done},        32'd0);
    check("rst_err",   {31'd0, err_timeout}, 32'd0);
    reset_n = 1'b1;
    tick(1);
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);

    // 2. nominal A5 with exact synchronizer latency
    in_valid = 1'b1;
    in_data  = 8'hA5;
    tick(1);
    in_valid = 1'b0;
    in_data  = 8'h00;
    check("nom_req",   {31'd0, tx_req},   32'd1);
    check("nom_data",  {24'd0, tx_data},  32'hA5);
    check("nom_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("nom_hold", {23'd0, tx_req, tx_data}, {23'd0, 1'b1, 8'hA5});
    end
    tx_ack = 1'b1;
    tick(2);
    check("nom_req_still", {31'd0, tx_req}, 32'd1);
    tick(1);
    check("nom_req_fall", {31'd0, tx_req}, 32'd0);
    check("nom_rel_data", {24'd0, tx_data}, 32'hA5);
    for (int i = 0; i < 4; i++) begin
      check("nom_release", {30'd0, in_ready, done}, 32'd0);
      tick(1);
    end
    tx_ack = 1'b0;
    tick(2);
    check("nom_done_early", {31'd0, done}, 32'd0);
    tick(1);
    check("nom_done",       {31'd0, done},     32'd1);
    check("nom_done_ready", {31'd0, in_ready}, 32'd1);
    check("nom_done_err",   {31'd0, err_timeout}, 32'd0);
    tick(1);
    check("nom_done_once", {31'd0, done}, 32'd0);

    // 3. back-pressure: 3C offered while 11 is in flight
    in_valid = 1'b1;
    in_data  = 8'h11;
    tick(1);
    in_data = 8'h3C;
    check("bp_first", {23'd0, tx_req, tx_data}, {23'd0, 1'b1, 8'h11});
    handshake(8'h11, 3, 2, 0);
    check("bp_hold",  {24'd0, tx_data},  32'h11);
    check("bp_ready", {31'd0, in_ready}, 32'd1);
    tick(1);
    in_valid = 1'b0;
    check("bp_second", {23'd0, tx_req, tx_data}, {23'd0, 1'b1, 8'h3C});
    handshake(8'h3C, 1, 1, 0);

    // stale ack high at accept: REQ exits on the first REQ edge
    tx_ack = 1'b1;
    tick(3);
    in_valid = 1'b1;
    in_data  = 8'h96;
    tick(1);
    in_valid = 1'b0;
    check("stale_req", {31'd0, tx_req}, 32'd1);
    tick(1);
    check("stale_exit", {31'd0, tx_req}, 32'd0);
    tx_ack = 1'b0;
    wait_for("stale_done", 1, 1'b1, 8);

    // 6. random ack phase, 1000 transfers
    tick(1);
    d0 = n_done;
    e0 = n_err;
    for (int i = 0; i < 1000; i++) begin
      w = 8'($urandom_range(0, 255));
      in_valid = 1'b1;
      in_data  = w;
      tick(1);
      in_valid = 1'b0;
      handshake(w, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                int'($urandom_range(1, 9)));
    end
    tick(2);
    check("rand_done_cnt", n_done - d0, 32'd1000);
    check("rand_err_cnt",  n_err - e0,  32'd0);

    // 4. timeout with TIMEOUT_CYC=16 and no ack
    d0 = n_done;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    tick(1);
    in_valid = 1'b0;
    tick(15);
    check("to_before", {30'd0, tx_req, err_timeout}, {30'd0, 1'b1, 1'b0});
    tick(1);
    check("to_pulse", {30'd0, tx_req, err_timeout}, {30'd0, 1'b0, 1'b1});
    check("to_no_done", {31'd0, done}, 32'd0);
    tick(1);
    check("to_pulse_once", {31'd0, err_timeout}, 32'd0);
    check("to_ready", {31'd0, in_ready}, 32'd1);
    tick(2);
    check("to_done_cnt", n_done - d0, 32'd0);

    // 5. async reset mid-REQ
    d0 = n_done;
    e0 = n_err;
    in_valid = 1'b1;
    in_data  = 8'hC3;
    tick(1);
    in_valid = 1'b0;
    tick(2);
    #2;
    check("ar_pre_req", {31'd0, tx_req}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("ar_req_drop", {31'd0, tx_req}, 32'd0);
    check("ar_ready",    {31'd0, in_ready}, 32'd1);
    tick(2);
    reset_n = 1'b1;
    tick(2);
    check("ar_post_ready", {31'd0, in_ready}, 32'd1);
    check("ar_post_data",  {24'd0, tx_data},  32'd0);
    check("ar_no_done",    n_done - d0, 32'd0);
    check("ar_no_err",     n_err - e0,  32'd0);

    check("pulse_exclusive", n_both, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
